// File: rtl/pulse_meter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pulse_meter_if
// Purpose  : Measurement result handshake between pulse_meter and its consumer.
//            The producer holds a result on m_width/m_level/m_sat while
//            m_valid is high; the consumer accepts it with m_ready.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_meter_if #(
  parameter int CNT_W = 16
);
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_width;
  logic             m_level;
  logic             m_sat;

  // Producer side: drives the held result, observes acceptance.
  modport master (
    output m_valid,
    output m_width,
    output m_level,
    output m_sat,
    input  m_ready
  );

  // Consumer side: observes the held result, drives acceptance.
  modport slave (
    input  m_valid,
    input  m_width,
    input  m_level,
    input  m_sat,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/pulse_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pulse_meter
// Purpose  : Measures the duration, in clk cycles, of each constant-level
//            interval of an asynchronous input. Each completed interval is
//            offered through a one-entry valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_meter #(
  parameter int CNT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        en,
  input  wire logic        sig_in,
  pulse_meter_if.master    mbus,
  output logic             overrun,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_done;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             w_edge;

  logic [CNT_W-1:0] r_cnt;

  logic             r_valid;
  logic [CNT_W-1:0] r_width;
  logic             r_level;
  logic             r_sat;
  logic             r_overrun;
  logic [15:0]      r_edge_count;

  logic             w_load;
  logic             w_accept;

  // An edge is any difference between the synchronized level and its history.
  assign w_edge   = r_sync2 ^ r_prev;

  // Result register accepts a new interval when empty or being drained now.
  assign w_accept = r_valid & mbus.m_ready;
  assign w_load   = w_done & (~r_valid | mbus.m_ready);

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; an interval completes only on an edge while measuring and enabled.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        // The interval running at arm time is partial, so wait for an edge.
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_edge) begin
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        // Dropping en discards the interval in progress.
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_edge) begin
          w_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Interval counter: restarts at 1 on every edge, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt == MEASURE) begin
      if (w_edge) begin
        r_cnt <= c_CNT_ONE;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // One-entry result register with same-cycle accept and reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_width <= '0;
      r_level <= 1'b0;
      r_sat   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_width <= r_cnt;
      r_level <= r_prev;
      r_sat   <= (r_cnt == c_CNT_MAX);
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun: a completed interval found the result register full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_done && r_valid && !mbus.m_ready) begin
      r_overrun <= 1'b1;
    end
  end

  // Free-running edge counter, active in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_count <= '0;
    end else if (w_edge) begin
      r_edge_count <= r_edge_count + 16'd1;
    end
  end

  assign mbus.m_valid = r_valid;
  assign mbus.m_width = r_width;
  assign mbus.m_level = r_level;
  assign mbus.m_sat   = r_sat;
  assign overrun      = r_overrun;
  assign edge_count   = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pulse_meter
// Purpose  : Directed self-checking bench for pulse_meter. A 16-bit instance
//            and a 4-bit instance share clk/rst/en/sig_in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_meter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sig_in;
  logic        ovr16;
  logic        ovr4;
  logic [15:0] ec16;
  logic [15:0] ec4;

  int n_cmp;
  int n_bad;

  pulse_meter_if #(.CNT_W(16)) if16 ();
  pulse_meter_if #(.CNT_W(4))  if4 ();

  pulse_meter #(.CNT_W(16)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .mbus       (if16),
    .overrun    (ovr16),
    .edge_count (ec16)
  );

  pulse_meter #(.CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .mbus       (if4),
    .overrun    (ovr4),
    .edge_count (ec4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    if16.m_ready = 1'b0; if4.m_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b expected 0", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd0) begin n_bad++; $display("FAIL reset_width: got %0d expected 0", if16.m_width); end
    n_cmp++; if (if16.m_level !== 1'b0) begin n_bad++; $display("FAIL reset_level: got %0b expected 0", if16.m_level); end
    n_cmp++; if (if16.m_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %0b expected 0", if16.m_sat); end
    n_cmp++; if (ovr16 !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %0b expected 0", ovr16); end
    n_cmp++; if (ec16 !== 16'd0) begin n_bad++; $display("FAIL reset_edge_count: got %0d expected 0", ec16); end
    n_cmp++; if (if4.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid4: got %0b expected 0", if4.m_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1; if16.m_ready = 1'b1; sig_in = 1'b0;
    repeat (3) tick();
    sig_in = 1'b1;
    repeat (50) tick();
    sig_in = 1'b0;
    repeat (2) tick();
    n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %0b expected 0", if16.m_valid); end
    tick();
    n_cmp++; if (if16.m_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b expected 1", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd50) begin n_bad++; $display("FAIL basic_width: got %0d expected 50", if16.m_width); end
    n_cmp++; if (if16.m_level !== 1'b1) begin n_bad++; $display("FAIL basic_level: got %0b expected 1", if16.m_level); end
    n_cmp++; if (if16.m_sat !== 1'b0) begin n_bad++; $display("FAIL basic_sat: got %0b expected 0", if16.m_sat); end
    tick();
    n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_accept: got %0b expected 0", if16.m_valid); end
    n_cmp++; if (ec16 !== 16'd2) begin n_bad++; $display("FAIL basic_edge_count: got %0d expected 2", ec16); end
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; if16.m_ready = 1'b1; if4.m_ready = 1'b1; sig_in = 1'b0;
    repeat (3) tick();
    sig_in = 1'b1;
    repeat (20) tick();
    sig_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (if4.m_valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid: got %0b expected 1", if4.m_valid); end
    n_cmp++; if (if4.m_width !== 4'd15) begin n_bad++; $display("FAIL sat_width: got %0d expected 15", if4.m_width); end
    n_cmp++; if (if4.m_sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %0b expected 1", if4.m_sat); end
    n_cmp++; if (if4.m_level !== 1'b1) begin n_bad++; $display("FAIL sat_level: got %0b expected 1", if4.m_level); end
    n_cmp++; if (if16.m_width !== 16'd20) begin n_bad++; $display("FAIL sat_wide_width: got %0d expected 20", if16.m_width); end
    n_cmp++; if (if16.m_sat !== 1'b0) begin n_bad++; $display("FAIL sat_wide_flag: got %0b expected 0", if16.m_sat); end
    repeat (3) tick();
    sig_in = 1'b1;
    repeat (3) tick();
    n_cmp++; if (if4.m_valid !== 1'b1) begin n_bad++; $display("FAIL sat_next_valid: got %0b expected 1", if4.m_valid); end
    n_cmp++; if (if4.m_width !== 4'd6) begin n_bad++; $display("FAIL sat_next_width: got %0d expected 6", if4.m_width); end
    n_cmp++; if (if4.m_sat !== 1'b0) begin n_bad++; $display("FAIL sat_next_flag: got %0b expected 0", if4.m_sat); end
    n_cmp++; if (if4.m_level !== 1'b0) begin n_bad++; $display("FAIL sat_next_level: got %0b expected 0", if4.m_level); end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; if16.m_ready = 1'b0; sig_in = 1'b0;
    repeat (3) tick();
    sig_in = 1'b1;
    repeat (10) tick();
    sig_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (if16.m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_first_valid: got %0b expected 1", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd10) begin n_bad++; $display("FAIL bp_first_width: got %0d expected 10", if16.m_width); end
    n_cmp++; if (ovr16 !== 1'b0) begin n_bad++; $display("FAIL bp_no_overrun_yet: got %0b expected 0", ovr16); end
    repeat (4) tick();
    sig_in = 1'b1;
    n_cmp++; if (if16.m_width !== 16'd10) begin n_bad++; $display("FAIL bp_stable_width: got %0d expected 10", if16.m_width); end
    repeat (3) tick();
    n_cmp++; if (if16.m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_held_valid: got %0b expected 1", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd10) begin n_bad++; $display("FAIL bp_held_width: got %0d expected 10", if16.m_width); end
    n_cmp++; if (if16.m_level !== 1'b1) begin n_bad++; $display("FAIL bp_held_level: got %0b expected 1", if16.m_level); end
    n_cmp++; if (ovr16 !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %0b expected 1", ovr16); end
    if16.m_ready = 1'b1;
    tick();
    n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got %0b expected 0", if16.m_valid); end
    repeat (3) tick();
    n_cmp++; if (ovr16 !== 1'b1) begin n_bad++; $display("FAIL bp_overrun_sticky: got %0b expected 1", ovr16); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1; if16.m_ready = 1'b0; sig_in = 1'b0;
    repeat (3) tick();
    sig_in = 1'b1;
    repeat (10) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    sig_in = 1'b1;
    repeat (2) tick();
    n_cmp++; if (if16.m_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_first_valid: got %0b expected 1", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd10) begin n_bad++; $display("FAIL b2b_first_width: got %0d expected 10", if16.m_width); end
    if16.m_ready = 1'b1;
    tick();
    n_cmp++; if (if16.m_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_kept: got %0b expected 1", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd5) begin n_bad++; $display("FAIL b2b_second_width: got %0d expected 5", if16.m_width); end
    n_cmp++; if (if16.m_level !== 1'b0) begin n_bad++; $display("FAIL b2b_second_level: got %0b expected 0", if16.m_level); end
    n_cmp++; if (ovr16 !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %0b expected 0", ovr16); end
    tick();
    n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %0b expected 0", if16.m_valid); end
  endtask

  task automatic test_reset_mid_measure();
    do_reset();
    en = 1'b1; if16.m_ready = 1'b1; sig_in = 1'b0;
    repeat (3) tick();
    sig_in = 1'b1;
    repeat (25) tick();
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %0b expected 0", if16.m_valid); end
    n_cmp++; if (if16.m_width !== 16'd0) begin n_bad++; $display("FAIL rmid_width: got %0d expected 0", if16.m_width); end
    n_cmp++; if (if16.m_level !== 1'b0) begin n_bad++; $display("FAIL rmid_level: got %0b expected 0", if16.m_level); end
    n_cmp++; if (if16.m_sat !== 1'b0) begin n_bad++; $display("FAIL rmid_sat: got %0b expected 0", if16.m_sat); end
    n_cmp++; if (ovr16 !== 1'b0) begin n_bad++; $display("FAIL rmid_overrun: got %0b expected 0", ovr16); end
    n_cmp++; if (ec16 !== 16'd0) begin n_bad++; $display("FAIL rmid_edge_count: got %0d expected 0", ec16); end
    for (int i = 0; i < 20; i++) begin
      if (i == 14) sig_in = 1'b0;
      tick();
      n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_result[%0d]: got %0b expected 0", i, if16.m_valid); end
    end
    n_cmp++; if (ec16 !== 16'd2) begin n_bad++; $display("FAIL rmid_edges_after: got %0d expected 2", ec16); end
  endtask

  task automatic test_en_low();
    do_reset();
    en = 1'b0; if16.m_ready = 1'b1; sig_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = ~sig_in;
      for (int j = 0; j < 4; j++) begin
        tick();
        n_cmp++; if (if16.m_valid !== 1'b0) begin n_bad++; $display("FAIL enlow_valid[%0d]: got %0b expected 0", i, if16.m_valid); end
      end
    end
    n_cmp++; if (ec16 !== 16'd5) begin n_bad++; $display("FAIL enlow_edge_count: got %0d expected 5", ec16); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_measure();
    test_en_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
